muldiv_unit: RTL

Multi-cycle multiply/divide unit that owns the HI/LO registers for the pipelined MIPS core. It sits in the E stage beside the ALU and executes mult, multu, div, divu, madd, mthi and mtlo. It models fixed MULT/DIV latencies and drives a busy flag. The hazard unit stalls D on busy whenever the D-stage instruction is mcalc, mt or mf.

---
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// HI/LO owner for the E stage: mult, multu, div, divu, madd, mthi, mtlo.
// Results are computed at accept and released after a fixed latency.
module muldiv_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   phi_q, phi_d;
    logic [31:0]   plo_q, plo_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic [63:0] smul_w, umul_w, madd_w;
    logic        rs_neg, rt_neg, rt_zero;
    logic [31:0] rs_abs, rt_abs, rt_safe, rt_abs_safe;
    logic [31:0] aq_w, ar_w, sq_w, sr_w, uq_w, ur_w;

    assign smul_w = $signed({{32{rs_val[31]}}, rs_val})
                  * $signed({{32{rt_val[31]}}, rt_val});
    assign umul_w = {32'd0, rs_val} * {32'd0, rt_val};
    assign madd_w = {hi_q, lo_q} + smul_w;

    assign rs_neg      = rs_val[31];
    assign rt_neg      = rt_val[31];
    assign rt_zero     = (rt_val == 32'd0);
    assign rs_abs      = rs_neg ? (~rs_val + 32'd1) : rs_val;
    assign rt_abs      = rt_neg ? (~rt_val + 32'd1) : rt_val;
    assign rt_safe     = rt_zero ? 32'd1 : rt_val;
    assign rt_abs_safe = rt_zero ? 32'd1 : rt_abs;

    // Signed divide on magnitudes; remainder follows the dividend's sign.
    assign aq_w = rs_abs / rt_abs_safe;
    assign ar_w = rs_abs % rt_abs_safe;
    assign sq_w = rt_zero ? (rs_neg ? 32'd1 : 32'hFFFF_FFFF)
                : ((rs_neg ^ rt_neg) ? (~aq_w + 32'd1) : aq_w);
    assign sr_w = rt_zero ? rs_val
                : (rs_neg ? (~ar_w + 32'd1) : ar_w);
    assign uq_w = rt_zero ? 32'hFFFF_FFFF : (rs_val / rt_safe);
    assign ur_w = rt_zero ? rs_val : (rs_val % rt_safe);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (md_op)
                        OP_MULT: begin
                            {phi_d, plo_d} = smul_w;
                            cnt_d          = MUL_CNT;
                            state_d        = RUN;
                        end
                        OP_MULTU: begin
                            {phi_d, plo_d} = umul_w;
                            cnt_d          = MUL_CNT;
                            state_d        = RUN;
                        end
                        OP_MADD: begin
                            {phi_d, plo_d} = madd_w;
                            cnt_d          = MUL_CNT;
                            state_d        = RUN;
                        end
                        OP_DIV: begin
                            phi_d   = sr_w;
                            plo_d   = sq_w;
                            cnt_d   = DIV_CNT;
                            state_d = RUN;
                        end
                        OP_DIVU: begin
                            phi_d   = ur_w;
                            plo_d   = uq_w;
                            cnt_d   = DIV_CNT;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // start is deliberately ignored here
                if (cnt_q == ONE_CNT) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - ONE_CNT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
